// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared types for the SPI/host RAM arbiter
//
// Purpose: command encodings, FSM state enum and requester ids used by
//          spi_ram_arbiter and rr_arb2.
// Ports:   none (package).
package spi_ram_pkg;

  // Two-bit command field carried in rx_data[DATA_W+1:DATA_W].
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RDATA  = 2'b10
  } state_e;

  // Values double as the bit index of each side in the arbiter req/gnt vectors.
  typedef enum logic {
    REQ_SPI  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// rtl/spi_ram_arbiter_if.sv - SPI frame, host and RAM port bundle
//
// Purpose: groups every non-clock signal of spi_ram_arbiter.
// Ports:   SPI side  rx_valid, rx_data, tx_data, tx_valid, rx_ovf, ovf_clr
//          host side h_req, h_we, h_addr, h_wdata, h_gnt, h_rdata, h_rvalid
//          RAM side  ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
// Modports: slave = the arbiter, master = its environment.
interface spi_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W+1:0] rx_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              rx_ovf;
  logic              ovf_clr;
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic [DATA_W-1:0] h_rdata;
  logic              h_rvalid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  rx_valid, rx_data, ovf_clr, h_req, h_we, h_addr, h_wdata, ram_rdata,
    output tx_data, tx_valid, rx_ovf, h_gnt, h_rdata, h_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output rx_valid, rx_data, ovf_clr, h_req, h_we, h_addr, h_wdata, ram_rdata,
    input  tx_data, tx_valid, rx_ovf, h_gnt, h_rdata, h_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// rtl/spi_ram_arbiter_rr_arb2.sv - two-way round-robin arbiter
//
// Purpose: one-hot grant between SPI (bit 0) and host (bit 1); on a tie the
//          side not granted last wins. last grant resets to host.
// Ports:   clk, rstn (async, active-low)
//          req[1:0]  in   request vector
//          accept    in   grant is taken this cycle; updates last grant
//          gnt[1:0]  out  one-hot combinational grant
module rr_arb2
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  req_id_e last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == REQ_HOST) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= REQ_HOST;
    end else if (accept && (gnt != 2'b00)) begin
      last_q <= (gnt == 2'b10) ? REQ_HOST : REQ_SPI;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - SPI command decoder and shared RAM port sequencer
//
// Purpose: decodes 10-bit SPI frames, owns wr_addr/rd_addr, holds a 1-deep
//          SPI pending op, and round-robins the single RAM port between SPI
//          and a local host. Read data returns to the side that issued it.
// Ports:   clk, rstn (async, active-low)
//          bus  spi_ram_arbiter_if.slave (SPI frames, host requests, RAM port)
// Config:  SPI_RAM_ARB_AUTOINC_EN - post-increment wr_addr/rd_addr on each
//          captured write/read op (wraps at 2**ADDR_W).
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  spi_ram_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic              pend_valid_q, pend_we_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_wdata_q;
  req_id_e           acc_owner_q;
  logic              acc_we_q;
  logic [ADDR_W-1:0] acc_addr_q;
  logic [DATA_W-1:0] acc_wdata_q;

  cmd_e              rx_cmd;
  logic [DATA_W-1:0] rx_pl;
  logic              frame_op, frame_we, frame_drop;
  logic [ADDR_W-1:0] frame_addr;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic [1:0]        req, gnt;
  logic              accept, spi_taken, host_taken;

  assign rx_cmd     = cmd_e'(bus.rx_data[DATA_W+1:DATA_W]);
  assign rx_pl      = bus.rx_data[DATA_W-1:0];
  assign frame_op   = bus.rx_valid && (rx_cmd == CMD_WR_DATA || rx_cmd == CMD_RD_DATA);
  assign frame_we   = (rx_cmd == CMD_WR_DATA);
  assign frame_addr = frame_we ? wr_addr_q : rd_addr_q;

  // An arriving op frame requests immediately; if it wins straight away it
  // bypasses the pending register, otherwise it waits there. An occupied
  // pending register is always older and is served first.
  assign spi_we    = pend_valid_q ? pend_we_q    : frame_we;
  assign spi_addr  = pend_valid_q ? pend_addr_q  : frame_addr;
  assign spi_wdata = pend_valid_q ? pend_wdata_q : rx_pl;
  assign req       = {bus.h_req, pend_valid_q | frame_op};

  assign spi_taken  = accept && gnt[REQ_SPI];
  assign host_taken = accept && gnt[REQ_HOST];
  // Pending only makes room when it is granted in this very cycle.
  assign frame_drop = frame_op && pend_valid_q && !spi_taken;

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.h_gnt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          accept  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = acc_we_q;
        bus.ram_addr  = acc_addr_q;
        bus.ram_wdata = acc_we_q ? acc_wdata_q : '0;
        bus.h_gnt     = (acc_owner_q == REQ_HOST);
        state_d       = acc_we_q ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else if (bus.rx_valid) begin
      case (rx_cmd)
        CMD_WR_ADDR: wr_addr_q <= ADDR_W'(rx_pl);
        CMD_RD_ADDR: rd_addr_q <= ADDR_W'(rx_pl);
`ifdef SPI_RAM_ARB_AUTOINC_EN
        CMD_WR_DATA: if (!frame_drop) wr_addr_q <= wr_addr_q + ADDR_W'(1);
        CMD_RD_DATA: if (!frame_drop) rd_addr_q <= rd_addr_q + ADDR_W'(1);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else if (frame_op && !frame_drop && (pend_valid_q || !spi_taken)) begin
      pend_valid_q <= 1'b1;
      pend_we_q    <= frame_we;
      pend_addr_q  <= frame_addr;
      pend_wdata_q <= rx_pl;
    end else if (spi_taken) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Snapshot of the winner, so the pending slot can be freed on entry to ACCESS.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_owner_q <= REQ_SPI;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
    end else if (accept) begin
      acc_owner_q <= host_taken ? REQ_HOST : REQ_SPI;
      acc_we_q    <= host_taken ? bus.h_we    : spi_we;
      acc_addr_q  <= host_taken ? bus.h_addr  : spi_addr;
      acc_wdata_q <= host_taken ? bus.h_wdata : spi_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      bus.h_rvalid <= 1'b0;
      bus.h_rdata  <= '0;
    end else begin
      bus.tx_valid <= 1'b0;
      bus.h_rvalid <= 1'b0;
      if (state_q == ST_RDATA) begin
        if (acc_owner_q == REQ_SPI) begin
          bus.tx_valid <= 1'b1;
          bus.tx_data  <= bus.ram_rdata;
        end else begin
          bus.h_rvalid <= 1'b1;
          bus.h_rdata  <= bus.ram_rdata;
        end
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            bus.rx_ovf <= 1'b0;
    else if (frame_drop)  bus.rx_ovf <= 1'b1;
    else if (bus.ovf_clr) bus.rx_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - self-checking bench for spi_ram_arbiter
//
// Purpose: cycle-by-cycle vector table for SPI/host traffic, arbitration and
//          overflow, then hand sequences for address auto-increment and
//          reset during a read. Honours SPI_RAM_ARB_AUTOINC_EN.
// Ports:   none (top-level bench).
module tb_spi_ram_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ram_q = 8'h00;
  assign bus.ram_rdata = ram_q;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_q <= mem[bus.ram_addr];
    end
  end

  // {en, we, addr, wdata, tx_valid, tx_data, h_gnt, h_rvalid, h_rdata, rx_ovf}
  logic [37:0] act;
  assign act = {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.tx_valid,
                bus.tx_data, bus.h_gnt, bus.h_rvalid, bus.h_rdata, bus.rx_ovf};

  typedef struct {
    logic        rv;
    logic [1:0]  cmd;
    logic [7:0]  pl;
    logic        hr;
    logic        hw;
    logic [7:0]  ha;
    logic [7:0]  hd;
    logic        oc;
    logic [37:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef SPI_RAM_ARB_AUTOINC_EN
  localparam logic [7:0] EXP_FF = 8'h11, EXP_00 = 8'h22, EXP_RD2 = 8'h22;
`else
  localparam logic [7:0] EXP_FF = 8'h22, EXP_00 = 8'h00, EXP_RD2 = 8'h22;
`endif

  function automatic string fmt(input logic [37:0] o);
    return $sformatf("en=%b we=%b addr=%h wd=%h txv=%b txd=%h gnt=%b hrv=%b hrd=%h ovf=%b",
                     o[37], o[36], o[35:28], o[27:20], o[19], o[18:11], o[10], o[9], o[8:1], o[0]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic add(input int rv, input int cmd, input logic [7:0] pl,
                     input int hr, input int hw, input logic [7:0] ha, input logic [7:0] hd,
                     input int oc, input int en, input int we, input logic [7:0] a,
                     input logic [7:0] wd, input int txv, input logic [7:0] txd,
                     input int gnt, input int hrv, input logic [7:0] hrd, input int ovf);
    vec_t v;
    v.rv  = (rv != 0);
    v.cmd = 2'(cmd);
    v.pl  = pl;
    v.hr  = (hr != 0);
    v.hw  = (hw != 0);
    v.ha  = ha;
    v.hd  = hd;
    v.oc  = (oc != 0);
    v.exp = {en != 0, we != 0, a, wd, txv != 0, txd, gnt != 0, hrv != 0, hrd, ovf != 0};
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.ovf_clr  = 1'b0;
    bus.h_req    = 1'b0;
    bus.h_we     = 1'b0;
    bus.h_addr   = '0;
    bus.h_wdata  = '0;
  endtask

  task automatic frame(input logic [1:0] cmd, input logic [7:0] pl);
    bus.rx_valid = 1'b1;
    bus.rx_data  = {cmd, pl};
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
  endtask

  task automatic wait_tx(input logic [7:0] want, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: tx_valid got 0 within 10 cycles want 1", nm);
    end else begin
      chk({nm, "_data"}, 64'(bus.tx_data), 64'(want));
      @(negedge clk);
      chk({nm, "_pulse"}, 64'(bus.tx_valid), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int strobes;
    //  rv cmd pl       hr hw ha     hd    oc  en we addr  wd     txv txd    gnt hrv hrd   ovf
    add(1, 0, 8'h10,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // c0
    add(1, 1, 8'hA5,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
    add(1, 2, 8'h10,   0, 0, 8'h00, 8'h00, 0,  1, 1, 8'h10, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0);
    add(1, 3, 8'h00,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // c5
    add(0, 0, 8'h00,   1, 1, 8'h20, 8'h3C, 0,  0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 2, 8'h10,   1, 1, 8'h20, 8'h3C, 0,  1, 1, 8'h20, 8'h3C, 0, 8'hA5, 1, 0, 8'h00, 0);
    add(1, 3, 8'h00,   1, 0, 8'h10, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00,   1, 0, 8'h10, 8'h00, 0,  1, 0, 8'h10, 8'h00, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00,   1, 0, 8'h10, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'h00, 0); // c10
    add(0, 0, 8'h00,   1, 0, 8'h10, 8'h00, 0,  0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00,   1, 0, 8'h10, 8'h00, 0,  1, 0, 8'h10, 8'h00, 0, 8'hA5, 1, 0, 8'h00, 0);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 0, 8'h30,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 1, 8'hA5, 0);
    add(1, 1, 8'h77,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'hA5, 0); // c15
    add(1, 2, 8'h30,   0, 0, 8'h00, 8'h00, 0,  1, 1, 8'h30, 8'h77, 0, 8'hA5, 0, 0, 8'hA5, 0);
    add(1, 3, 8'h00,   1, 0, 8'h20, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'hA5, 0);
    add(1, 1, 8'h99,   1, 0, 8'h20, 8'h00, 1,  1, 0, 8'h20, 8'h00, 0, 8'hA5, 1, 0, 8'hA5, 0);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'hA5, 1);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 1,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 1, 8'h3C, 1); // c20
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  1, 0, 8'h30, 8'h00, 0, 8'hA5, 0, 0, 8'h3C, 0);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0, 8'h3C, 0);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 1, 8'h77, 0, 0, 8'h3C, 0);
    add(0, 0, 8'h00,   0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 8'h77, 0, 0, 8'h3C, 0);

    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(act), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      bus.rx_valid = vq[i].rv;
      bus.rx_data  = {vq[i].cmd, vq[i].pl};
      bus.h_req    = vq[i].hr;
      bus.h_we     = vq[i].hw;
      bus.h_addr   = vq[i].ha;
      bus.h_wdata  = vq[i].hd;
      bus.ovf_clr  = vq[i].oc;
      @(negedge clk);
      n_chk++;
      if (act !== vq[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %s want %s", i, fmt(act), fmt(vq[i].exp));
      end
      @(posedge clk); #1;
    end
    idle_inputs();

    // Two writes starting at the top address, then two reads from the top.
    frame(2'b00, 8'hFF);
    frame(2'b01, 8'h11);
    frame(2'b01, 8'h22);
    repeat (5) @(posedge clk);
    #1;
    chk("autoinc_mem_ff", 64'(mem[8'hFF]), 64'(EXP_FF));
    chk("autoinc_mem_00", 64'(mem[8'h00]), 64'(EXP_00));
    frame(2'b10, 8'hFF);
    frame(2'b11, 8'h00);
    wait_tx(EXP_FF, "autoinc_rd1");
    frame(2'b11, 8'h00);
    wait_tx((EXP_FF == 8'h11) ? EXP_00 : EXP_RD2, "autoinc_rd2");

    // Reset while a SPI read sits in RDATA.
    frame(2'b00, 8'h00);
    frame(2'b01, 8'h5A);
    frame(2'b10, 8'h30);
    frame(2'b11, 8'h00);
    @(negedge clk);
    chk("rst_seq_access", 64'({bus.ram_en, bus.ram_we, bus.ram_addr}), 64'({1'b1, 1'b0, 8'h30}));
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'(act), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.tx_valid || bus.h_rvalid) strobes++;
    end
    chk("rst_no_strobe", 64'(strobes), 64'd0);
    @(posedge clk); #1;
    frame(2'b11, 8'h00);
    wait_tx(8'h5A, "rst_rd_addr0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Controller that sits between the SPI slave frame interface and a single-port synchronous RAM. It decodes 10-bit SPI command frames, owns the SPI read and write address registers, and sequences every RAM access. It also shares the one RAM port between the SPI path and a local host requester using two-way round-robin arbitration, and returns read data to whichever side issued the read.

## Interface
- ADDR_W, 8, RAM address width (depth 2**ADDR_W)
- DATA_W, 8, RAM data width
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset; clock clk
- rx_valid  in  1  SPI frame strobe, one cycle per frame
- rx_data  in  DATA_W+2  [DATA_W+1:DATA_W] command, [DATA_W-1:0] payload
- tx_data  out  DATA_W  SPI read data
- tx_valid  out  1  one-cycle strobe, tx_data valid
- rx_ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears rx_ovf
- h_req  in  1  host request, held until h_gnt
- h_we  in  1  host write (1) / read (0)
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  one-cycle grant pulse
- h_rdata  out  DATA_W  host read data
- h_rvalid  out  1  one-cycle strobe, h_rdata valid
- ram_en, ram_we  out  1  RAM port controls
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0

## Operation
- Commands:
  - 00: load wr_addr
  - 01: write payload at wr_addr
  - 10: load rd_addr
  - 11: read at rd_addr (payload ignored)
- Address loads (00/10) complete on the rx_valid edge. They never use the RAM port.
- Ops 01/11 go into a 1-deep SPI pending register. The register captures the op, the payload, and the current wr_addr or rd_addr at the moment of capture. A later address load does not change an already-pending op.
- If rx_valid carries 01/11 while pending is full and pending is not granted in that same cycle: the frame is dropped and rx_ovf is set.
  - rx_ovf is sticky until ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- FSM states IDLE, ACCESS, RDATA.
  - IDLE: if SPI pending and/or h_req is asserted, the arbiter picks a winner and the FSM goes to ACCESS.
  - ACCESS: ram_en=1 with the winner's we/addr/wdata; h_gnt=1 if the host won. Writes go to IDLE. Reads go to RDATA.
  - RDATA: capture ram_rdata into tx_data (SPI) or h_rdata (host). The strobe is asserted the following cycle. Then go to IDLE.
- Round-robin:
  - If both sides request, grant the side not granted last.
  - A single requester always wins.
  - last_grant resets to host, so SPI wins the first tie.
- The SPI pending register frees at the edge that enters ACCESS.

## Timing
- Reset values: all outputs 0, rx_ovf 0, wr_addr/rd_addr 0, pending empty, FSM IDLE, last_grant host.
- Write latency: request visible at edge N, ram_en high in cycle N+1.
- Read latency: ram_en in cycle N+1, ram_rdata in N+2, tx_valid/h_rvalid high in cycle N+3 only.
- Back-to-back: the next access starts at the earliest 1 cycle after a write ACCESS, or 1 cycle after RDATA.
- Worst-case SPI wait is one host access (3 cycles). Frames are spaced at least DATA_W+2 sclk apart, so overflow means a protocol violation.
- Reset mid-operation: the in-flight access is abandoned, no strobe is emitted, and the pending op is lost.
- tx_data and h_rdata hold their value between strobes.

## Configuration
- SPI_RAM_ARB_AUTOINC_EN defined:
  - wr_addr increments after each 01 capture, and rd_addr after each 11 capture.
  - Both wrap from 2**ADDR_W-1 to 0.
  - An address-load frame in the same cycle is impossible, since there is one frame per rx_valid.
- Undefined: addresses change only via commands 00/10.

## Structure
- Package spi_ram_pkg:
  - command encodings CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA
  - FSM state enum
  - requester id (REQ_SPI, REQ_HOST)
- One sub-module: rr_arb2 (2-way round-robin, req[1:0] in, one-hot gnt out, last-grant register updated on an accept strobe).

## Test plan
- Frames 00/0x10, 01/0xA5, 10/0x10, 11 -> RAM write at 0x10 data 0xA5; tx_valid one cycle with tx_data 0xA5, 3 cycles after the 11 frame.
- h_req read at 0x10 together with SPI pending read -> SPI served first, host next (h_gnt, then h_rvalid with 0xA5); repeat tie -> host first.
- Second 01 frame while pending full and host in ACCESS -> frame dropped, rx_ovf=1 until ovf_clr; set and clear in the same cycle -> stays 1.
- AUTOINC_EN: wr_addr 0xFF, two 01 writes -> data at 0xFF and 0x00; without the macro -> both at 0xFF.
- rstn asserted during RDATA -> no tx_valid, all outputs 0, next 11 reads rd_addr 0.
